alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched_if.sv | 44 ++++
 rtl/alu_sched.sv | 130 +++++++++++++
 tb/tb_alu_sched.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_sched_if.sv
// Bundle of requester, shared-ALU and response signals for alu_sched.
// slave = scheduler side, master = the environment (requesters, ALU, consumer).
interface alu_sched_if #(
  parameter int unsigned W = 16
);
  logic         a_valid;
  logic         a_ready;
  logic [3:0]   a_opcode;
  logic [W-1:0] a_in1;
  logic [W-1:0] a_in2;
  logic         b_valid;
  logic         b_ready;
  logic [3:0]   b_opcode;
  logic [W-1:0] b_in1;
  logic [W-1:0] b_in2;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [W-1:0] alu_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_id;
  logic         rsp_err;
  logic         busy;

  modport slave (
    input  a_valid, a_opcode, a_in1, a_in2,
    input  b_valid, b_opcode, b_in1, b_in2,
    input  alu_out, rsp_ready,
    output a_ready, b_ready,
    output alu_opcode, alu_in1, alu_in2,
    output rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

  modport master (
    output a_valid, a_opcode, a_in1, a_in2,
    output b_valid, b_opcode, b_in1, b_in2,
    output alu_out, rsp_ready,
    input  a_ready, b_ready,
    input  alu_opcode, alu_in1, alu_in2,
    input  rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );
endinterface

// File: rtl/alu_sched.sv
// Two-requester scheduler in front of one shared combinational ALU.
// Define ALU_SCHED_RR_EN for round-robin arbitration; default is fixed priority (A wins).
module alu_sched #(
  parameter int unsigned W       = 16,
  parameter logic [3:0]  NOOP_OP = 4'b0000
) (
  input logic       clk,
  input logic       clear,
  alu_sched_if.slave bus
);
  localparam int unsigned OPW = 4;
  localparam logic [OPW-1:0] OP_DIV    = 4'b0100;
  localparam logic [OPW-1:0] OP_ERR_LO = 4'b1001;
  localparam logic [OPW-1:0] OP_ERR_HI = 4'b1110;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         r_state;
  logic [OPW-1:0] r_alu_op;
  logic [W-1:0]   r_alu_in1;
  logic [W-1:0]   r_alu_in2;
  logic           r_rsp_valid;
  logic [W-1:0]   r_rsp_data;
  logic           r_rsp_id;
  logic           r_rsp_err;
`ifdef ALU_SCHED_RR_EN
  logic           r_ptr;  // 1 = favour B on the next tie
`endif

  logic           w_grant_a;
  logic           w_grant_b;
  logic [OPW-1:0] w_op;
  logic [W-1:0]   w_in1;
  logic [W-1:0]   w_in2;
  logic           w_err;

  // Grant decision and payload select; ready is only ever raised in IDLE out of reset.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (clear && (r_state == IDLE)) begin
`ifdef ALU_SCHED_RR_EN
      if (bus.a_valid && bus.b_valid) begin
        w_grant_a = !r_ptr;
        w_grant_b = r_ptr;
      end else begin
        w_grant_a = bus.a_valid;
        w_grant_b = bus.b_valid;
      end
`else
      w_grant_a = bus.a_valid;
      w_grant_b = bus.b_valid && !bus.a_valid;
`endif
    end
    w_op  = w_grant_b ? bus.b_opcode : bus.a_opcode;
    w_in1 = w_grant_b ? bus.b_in1    : bus.a_in1;
    w_in2 = w_grant_b ? bus.b_in2    : bus.a_in2;
    w_err = ((w_op >= OP_ERR_LO) && (w_op <= OP_ERR_HI)) ||
            ((w_op == OP_DIV) && (w_in2 == '0));
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state     <= IDLE;
      r_alu_op    <= NOOP_OP;
      r_alu_in1   <= '0;
      r_alu_in2   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
`ifdef ALU_SCHED_RR_EN
      r_ptr       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_a || w_grant_b) begin
            r_rsp_id <= w_grant_b;
`ifdef ALU_SCHED_RR_EN
            r_ptr    <= w_grant_a;
`endif
            // Rejected operations skip the ALU and answer straight away.
            if (w_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_alu_op  <= w_op;
              r_alu_in1 <= w_in1;
              r_alu_in2 <= w_in2;
              r_state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= bus.alu_out;
          r_rsp_err   <= 1'b0;
          r_alu_op    <= NOOP_OP;
          r_alu_in1   <= '0;
          r_alu_in2   <= '0;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.a_ready    = w_grant_a;
  assign bus.b_ready    = w_grant_b;
  assign bus.alu_opcode = r_alu_op;
  assign bus.alu_in1    = r_alu_in1;
  assign bus.alu_in2    = r_alu_in2;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small behavioural ALU on the shared port.
module tb_alu_sched;
  localparam int unsigned W = 16;

  logic clk;
  logic clear;
  int   n_tests;
  int   n_fail;

  alu_sched_if #(.W(W)) bus ();

  alu_sched #(.W(W), .NOOP_OP(4'b0000)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment ALU: 1111 (RESET) and unknown codes return 0.
  always_comb begin
    case (bus.alu_opcode)
      4'b0001: bus.alu_out = bus.alu_in1 + bus.alu_in2;
      4'b0010: bus.alu_out = bus.alu_in1 - bus.alu_in2;
      4'b0011: bus.alu_out = 16'(32'(bus.alu_in1) * 32'(bus.alu_in2));
      4'b0100: bus.alu_out = (bus.alu_in2 == '0) ? 16'hFFFF : bus.alu_in1 / bus.alu_in2;
      4'b0101: bus.alu_out = bus.alu_in1 & bus.alu_in2;
      4'b0110: bus.alu_out = bus.alu_in1 | bus.alu_in2;
      4'b0111: bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
      4'b1000: bus.alu_out = bus.alu_in1 << bus.alu_in2[3:0];
      default: bus.alu_out = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        b;
    logic [3:0]  op;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        err;
    logic [15:0] data;
    string       name;
  } vec_t;

  vec_t vecs[13];

  // One full transaction with rsp_ready asserted on the first RESP cycle.
  task automatic run_txn(input vec_t v);
    @(posedge clk); #1;
    if (v.b) begin
      bus.b_valid = 1'b1; bus.b_opcode = v.op; bus.b_in1 = v.in1; bus.b_in2 = v.in2;
    end else begin
      bus.a_valid = 1'b1; bus.a_opcode = v.op; bus.a_in1 = v.in1; bus.a_in2 = v.in2;
    end
    @(negedge clk);
    chk({v.name, ".a_ready"}, 32'(bus.a_ready), 32'(!v.b));
    chk({v.name, ".b_ready"}, 32'(bus.b_ready), 32'(v.b));
    chk({v.name, ".busy_idle"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    if (!v.err) begin
      @(negedge clk);
      chk({v.name, ".alu_op"}, 32'(bus.alu_opcode), 32'(v.op));
      chk({v.name, ".alu_in1"}, 32'(bus.alu_in1), 32'(v.in1));
      chk({v.name, ".alu_in2"}, 32'(bus.alu_in2), 32'(v.in2));
      chk({v.name, ".rsp_early"}, 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({v.name, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({v.name, ".rsp_data"}, 32'(bus.rsp_data), 32'(v.data));
    chk({v.name, ".rsp_id"}, 32'(bus.rsp_id), 32'(v.b));
    chk({v.name, ".rsp_err"}, 32'(bus.rsp_err), 32'(v.err));
    chk({v.name, ".alu_noop"}, 32'(bus.alu_opcode), 32'd0);
    chk({v.name, ".busy"}, 32'(bus.busy), 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk({v.name, ".done_busy"}, 32'(bus.busy), 32'd0);
    chk({v.name, ".done_rsp"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0]  = '{1'b0, 4'b0001, 16'd3,      16'd4,      1'b0, 16'd7,     "add_3_4"};
    vecs[1]  = '{1'b1, 4'b0100, 16'd8,      16'd0,      1'b1, 16'd0,     "div_by_0"};
    vecs[2]  = '{1'b0, 4'b1010, 16'd5,      16'd6,      1'b1, 16'd0,     "illegal_1010"};
    vecs[3]  = '{1'b1, 4'b0010, 16'd100,    16'd1,      1'b0, 16'd99,    "sub"};
    vecs[4]  = '{1'b0, 4'b0011, 16'd300,    16'd300,    1'b0, 16'd24464, "mult_trunc"};
    vecs[5]  = '{1'b1, 4'b0100, 16'd20,     16'd3,      1'b0, 16'd6,     "div"};
    vecs[6]  = '{1'b0, 4'b0111, 16'd11,     16'd13,     1'b0, 16'd6,     "xor"};
    vecs[7]  = '{1'b1, 4'b1110, 16'd1,      16'd1,      1'b1, 16'd0,     "illegal_1110"};
    vecs[8]  = '{1'b0, 4'b1111, 16'd9,      16'd9,      1'b0, 16'd0,     "reset_op"};
    vecs[9]  = '{1'b1, 4'b1000, 16'd5,      16'd2,      1'b0, 16'd20,    "op_1000"};
    vecs[10] = '{1'b0, 4'b1001, 16'd7,      16'd7,      1'b1, 16'd0,     "illegal_1001"};
    vecs[11] = '{1'b0, 4'b0101, 16'hF0F0,   16'h0FF0,   1'b0, 16'h00F0,  "and"};
    vecs[12] = '{1'b1, 4'b0000, 16'd4,      16'd4,      1'b0, 16'd0,     "noop_op"};

    // Reset: ready stays low even with a request pending.
    clear = 1'b0;
    bus.a_valid = 1'b1; bus.a_opcode = 4'b0001; bus.a_in1 = 16'd1; bus.a_in2 = 16'd1;
    bus.b_valid = 1'b0; bus.b_opcode = 4'b0000; bus.b_in1 = '0; bus.b_in2 = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.a_ready", 32'(bus.a_ready), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.alu_op", 32'(bus.alu_opcode), 32'd0);
    bus.a_valid = 1'b0;
    clear = 1'b1;

    for (int i = 0; i < 13; i++) run_txn(vecs[i]);

    // Backpressure: response held 5 cycles while B waits, no grant until the take.
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_opcode = 4'b0111; bus.a_in1 = 16'd11; bus.a_in2 = 16'd13;
    @(negedge clk);
    chk("bp.a_ready", 32'(bus.a_ready), 32'd1);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b1; bus.b_opcode = 4'b0001; bus.b_in1 = 16'd1; bus.b_in2 = 16'd1;
    @(negedge clk);
    chk("bp.b_ready_issue", 32'(bus.b_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp.rsp_data", 32'(bus.rsp_data), 32'd6);
      chk("bp.busy", 32'(bus.busy), 32'd1);
      chk("bp.readys", 32'({bus.a_ready, bus.b_ready}), 32'd0);
    end
    @(negedge clk);
    chk("bp.take_data", 32'(bus.rsp_data), 32'd6);
    chk("bp.take_b_ready", 32'(bus.b_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp.b_grant", 32'(bus.b_ready), 32'd1);
    chk("bp.b_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
    @(negedge clk);
    chk("bp.b_alu_op", 32'(bus.alu_opcode), 32'd1);
    @(negedge clk);
    chk("bp.b_rsp_data", 32'(bus.rsp_data), 32'd2);
    chk("bp.b_rsp_id", 32'(bus.rsp_id), 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    // Contention: both requesters keep MULT 2x2 pending, consumer always ready.
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_opcode = 4'b0011; bus.a_in1 = 16'd2; bus.a_in2 = 16'd2;
    bus.b_valid = 1'b1; bus.b_opcode = 4'b0011; bus.b_in1 = 16'd2; bus.b_in2 = 16'd2;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_b;
`ifdef ALU_SCHED_RR_EN
      exp_b = (k % 2) == 1;
`else
      exp_b = 1'b0;
`endif
      @(negedge clk);
      chk("cont.a_ready", 32'(bus.a_ready), 32'(!exp_b));
      chk("cont.b_ready", 32'(bus.b_ready), 32'(exp_b));
      @(negedge clk);
      @(negedge clk);
      chk("cont.rsp_data", 32'(bus.rsp_data), 32'd4);
      chk("cont.rsp_id", 32'(bus.rsp_id), 32'(exp_b));
    end
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset mid-ISSUE: operation dropped, outputs cleared at once.
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_opcode = 4'b0001; bus.a_in1 = 16'd3; bus.a_in2 = 16'd4;
    @(negedge clk);
    chk("rmid.a_ready", 32'(bus.a_ready), 32'd1);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    chk("rmid.in_issue", 32'(bus.alu_opcode), 32'd1);
    #2;
    clear = 1'b0;
    #1;
    chk("rmid.busy", 32'(bus.busy), 32'd0);
    chk("rmid.alu_op", 32'(bus.alu_opcode), 32'd0);
    chk("rmid.alu_in1", 32'(bus.alu_in1), 32'd0);
    chk("rmid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rmid.no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.rsp_ready = 1'b0;
    run_txn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
